// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared state encoding, word addresses and counter width for the sysid checker.
package sysid_checker_pkg;
  localparam int TMO_W = 16;
  localparam logic ID_WORD = 1'b0;
  localparam logic TS_WORD = 1'b1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    RD_TS   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/sysid_timeout_counter.sv
// sysid_timeout_counter: counts consecutive stalled cycles; expired flags the last tolerated stall.
module sysid_timeout_counter
  import sysid_checker_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);
  logic [TMO_W-1:0] count;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  end
  assign expired = enable && (count == limit - 1'b1);
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid words 0/1 over Avalon-MM and compares them against expected values.
// Define SYSID_CHECK_AUTOSTART_EN to run one check automatically after reset release.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0]      EXPECTED_ID        = 32'd0,
  parameter logic [31:0]      EXPECTED_TIMESTAMP = 32'd1455227776,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES     = 16'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);
  state_t state, state_nxt;
  logic go, rd_state, stall, expired;
`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_q <= 1'b1;
    else auto_q <= 1'b0;
  end
  assign go = start | auto_q;
`else
  assign go = start;
`endif
  assign rd_state = (state == RD_ID) || (state == RD_TS);
  assign stall    = rd_state && sysid_waitrequest;
  // Any accepted read or non-read state restarts the count, so it measures consecutive stalls per read.
  sysid_timeout_counter u_tmo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!stall),
    .enable  (stall),
    .limit   (TIMEOUT_CYCLES),
    .expired (expired)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go ? RD_ID : IDLE;
      RD_ID:   state_nxt = !sysid_waitrequest ? RD_TS : (expired ? DONE : RD_ID);
      RD_TS:   state_nxt = !sysid_waitrequest ? COMPARE : (expired ? DONE : RD_TS);
      COMPARE: state_nxt = DONE;
      DONE:    state_nxt = go ? RD_ID : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    sysid_read    = rd_state;
    sysid_address = (state == RD_TS) ? TS_WORD : ID_WORD;
    busy          = rd_state || (state == COMPARE);
    done          = (state == DONE);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value        <= '0;
      timestamp_value <= '0;
      match           <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      if (state == RD_ID && !sysid_waitrequest) id_value <= sysid_readdata;
      if (state == RD_TS && !sysid_waitrequest) timestamp_value <= sysid_readdata;
      if (state == COMPARE) match <= (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
      if (expired) begin
        match   <= 1'b0;
        timeout <= 1'b1;
      end
      if (state == DONE && go) begin
        match   <= 1'b0;
        timeout <= 1'b0;
      end
    end
  end
endmodule
